// File: rtl/serv_rf_shared_ram.sv
// serv_rf_shared_ram
// -------------------------------------------------------------------------
// One RAM holds the register files of CHANNELS SERV harts. Each hart has its
// own bank, and a round-robin arbiter gives RAM ownership to one hart at a
// time.
//
// req/gnt handshake: a channel holds i_req high for as long as it wants the
// RAM. o_gnt (registered, one-hot) marks the owner. A channel's i_wen/i_ren
// count only in cycles where its o_gnt and i_req are both high. The owner
// releases the RAM by dropping i_req. In that same cycle the next pending
// requester, if there is one, is granted, so there is no idle bubble.
// Enables from channels that do not own the RAM are ignored silently.
//
// Ports (channel c uses slice [c*W +: W] of each packed vector):
//   i_clk, i_rst_n      clock; asynchronous active-low reset
//   i_req / o_gnt       ownership request / one-hot registered grant
//   i_waddr/i_wdata/i_wen  per-channel write port (local word address)
//   i_raddr/i_ren       per-channel read port (local word address)
//   o_rdata             registered RAM output, copied to every channel slice
//   o_rvalid            one-hot; marks the channel whose read is returning
//   o_busy              some channel owns the RAM
//   o_perr, o_perr_ch   sticky parity error and channel of the first error
//                       (only when SERV_RF_SHARED_PARITY_EN is defined)
//   o_state             arbiter FSM state (0 = IDLE, 1 = OWNED), for debug
//
// Optional feature macro: SERV_RF_SHARED_PARITY_EN. When it is defined, each
// word gets one extra bit that stores even parity.
// -------------------------------------------------------------------------
module serv_rf_shared_ram #(
  parameter int WIDTH    = 2,
  parameter int CSR_REGS = 4,
  parameter int CHANNELS = 2,
  parameter int L2D      = $clog2((32 + CSR_REGS) * 32 / WIDTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [CHANNELS-1:0]          i_req,
  output logic [CHANNELS-1:0]          o_gnt,
  input  logic [CHANNELS*L2D-1:0]      i_waddr,
  input  logic [CHANNELS*WIDTH-1:0]    i_wdata,
  input  logic [CHANNELS-1:0]          i_wen,
  input  logic [CHANNELS*L2D-1:0]      i_raddr,
  input  logic [CHANNELS-1:0]          i_ren,
  output logic [CHANNELS*WIDTH-1:0]    o_rdata,
  output logic [CHANNELS-1:0]          o_rvalid,
  output logic                         o_busy,
`ifdef SERV_RF_SHARED_PARITY_EN
  output logic                         o_perr,
  output logic [$clog2(CHANNELS)-1:0]  o_perr_ch,
`endif
  output logic                         o_state
);

  localparam int DEPTH = (32 + CSR_REGS) * 32 / WIDTH;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
`ifdef SERV_RF_SHARED_PARITY_EN
  localparam int MW    = WIDTH + 1;
`else
  localparam int MW    = WIDTH;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       own_q, own_d;
  logic [CW-1:0]       last_q, last_d;
  logic [CHANNELS-1:0] gnt_q, gnt_d;
  logic [CHANNELS-1:0] rvalid_q;

  logic [CW-1:0]       pick;
  logic [CW-1:0]       idx;
  logic                found;

  // Round-robin search that starts at last+1. The previous winner is looked
  // at last, so it can only win again when nobody else is requesting.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = CW'((int'(last_q) + i) % CHANNELS);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = OWNED;
          own_d       = pick;
          last_d      = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
        end
      end
      OWNED: begin
        if (!i_req[own_q]) begin
          // The owner is releasing, so its i_req is low and it cannot be
          // picked. Any hit is another channel, and it is granted at the
          // same edge.
          if (found) begin
            own_d       = pick;
            last_d      = pick;
            gnt_d       = '0;
            gnt_d[pick] = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      own_q   <= '0;
      last_q  <= CW'(CHANNELS - 1);
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  // Access gating: only the live owner's enables reach the RAM.
  logic             owner_live;
  logic             wen_acc;
  logic             ren_acc;
  logic [L2D-1:0]   waddr_sel;
  logic [L2D-1:0]   raddr_sel;
  logic [WIDTH-1:0] wdata_sel;
  logic [MW-1:0]    wword;

  assign owner_live = (state_q == OWNED) && gnt_q[own_q] && i_req[own_q];
  assign wen_acc    = owner_live && i_wen[own_q];
  assign ren_acc    = owner_live && i_ren[own_q];
  assign waddr_sel  = i_waddr[own_q*L2D +: L2D];
  assign raddr_sel  = i_raddr[own_q*L2D +: L2D];
  assign wdata_sel  = i_wdata[own_q*WIDTH +: WIDTH];

`ifdef SERV_RF_SHARED_PARITY_EN
  assign wword = {^wdata_sel, wdata_sel};
`else
  assign wword = wdata_sel;
`endif

  // The first index is the bank (channel) and the second is the local word,
  // which matches the physical address {channel, local}. Bank selection
  // always uses own_q, so a channel cannot reach another channel's bank.
  // The contents are not reset. A read and a write to the same word in the
  // same cycle return the old word.
  logic [MW-1:0] mem [CHANNELS][DEPTH];
  logic [MW-1:0] rword_q;

  always_ff @(posedge i_clk) begin
    if (wen_acc) mem[own_q][waddr_sel] <= wword;
    if (ren_acc) rword_q <= mem[own_q][raddr_sel];
  end

  // rvalid is tied to the channel that issued the read. The response
  // therefore still goes to the issuer if ownership changes before it
  // returns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= '0;
      if (ren_acc) rvalid_q[own_q] <= 1'b1;
    end
  end

`ifdef SERV_RF_SHARED_PARITY_EN
  logic [CW-1:0] rd_ch_q;
  logic          perr_q;
  logic [CW-1:0] perr_ch_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ch_q   <= '0;
      perr_q    <= 1'b0;
      perr_ch_q <= '0;
    end else begin
      if (ren_acc) rd_ch_q <= own_q;
      // With even parity, the XOR of data and parity bit is zero for a
      // good word. Only the first error is recorded.
      if (!perr_q && (|rvalid_q) && (^rword_q)) begin
        perr_q    <= 1'b1;
        perr_ch_q <= rd_ch_q;
      end
    end
  end

  assign o_perr    = perr_q;
  assign o_perr_ch = perr_ch_q;
`endif

  assign o_gnt    = gnt_q;
  assign o_rvalid = rvalid_q;
  assign o_rdata  = {CHANNELS{rword_q[WIDTH-1:0]}};
  assign o_busy   = |gnt_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_serv_rf_shared_ram.sv
// tb_serv_rf_shared_ram
// Directed bench for serv_rf_shared_ram with the default parameters
// (2 channels, 2-bit words, 10-bit local addresses). The stimulus process
// drives requests and accesses and checks grants directly. For every read it
// expects to be accepted, it pushes the expected {rvalid, data}. A separate
// monitor pops an entry and compares it each time o_rvalid is seen.
module tb_serv_rf_shared_ram;
  localparam int W   = 2;
  localparam int CH  = 2;
  localparam int L2D = 10;

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     req;
  logic [CH-1:0]     gnt;
  logic [CH*L2D-1:0] waddr;
  logic [CH*W-1:0]   wdata;
  logic [CH-1:0]     wen;
  logic [CH*L2D-1:0] raddr;
  logic [CH-1:0]     ren;
  logic [CH*W-1:0]   rdata;
  logic [CH-1:0]     rvalid;
  logic              busy;
  logic              state;
`ifdef SERV_RF_SHARED_PARITY_EN
  logic              perr;
  logic              perr_ch;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [CH+W-1:0] exp_q[$];

  serv_rf_shared_ram dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .o_gnt    (gnt),
    .i_waddr  (waddr),
    .i_wdata  (wdata),
    .i_wen    (wen),
    .i_raddr  (raddr),
    .i_ren    (ren),
    .o_rdata  (rdata),
    .o_rvalid (rvalid),
    .o_busy   (busy),
`ifdef SERV_RF_SHARED_PARITY_EN
    .o_perr   (perr),
    .o_perr_ch(perr_ch),
`endif
    .o_state  (state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Checking helpers and driver tasks
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Stimulus changes 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int ch, input int a, input logic [W-1:0] d);
    logic [L2D-1:0] av;
    av = L2D'(a);
    wen[ch] = 1'b1;
    waddr[ch*L2D +: L2D] = av;
    wdata[ch*W +: W] = d;
  endtask

  task automatic set_rd(input int ch, input int a);
    logic [L2D-1:0] av;
    av = L2D'(a);
    ren[ch] = 1'b1;
    raddr[ch*L2D +: L2D] = av;
  endtask

  task automatic clr();
    wen = '0;
    ren = '0;
  endtask

  task automatic expect_rd(input int ch, input logic [W-1:0] d);
    logic [CH-1:0] oh;
    oh = CH'(1 << ch);
    exp_q.push_back({oh, d});
  endtask

  // Monitor: samples 3 time units after each rising edge.
  initial begin
    logic [CH+W-1:0] e;
    forever begin
      @(posedge clk);
      #3;
      if (rvalid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 32'(rvalid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_resp", 32'({rvalid, rdata}), 32'({e[CH+W-1:W], e[W-1:0], e[W-1:0]}));
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    rst_n = 1'b0;
    req   = '0;
    waddr = '0;
    wdata = '0;
    wen   = '0;
    raddr = '0;
    ren   = '0;
    repeat (2) cyc();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
`ifdef SERV_RF_SHARED_PARITY_EN
    chk("rst_perr", 32'({perr, perr_ch}), 32'd0);
`endif
    rst_n = 1'b1;
    cyc();
    chk("idle_gnt", 32'(gnt), 32'd0);

    // First grant, one cycle after the request
    req = 2'b01;
    cyc();
    chk("gnt_ch0", 32'(gnt), 32'b01);
    chk("busy_ch0", 32'(busy), 32'd1);
    chk("state_owned", 32'(state), 32'd1);

    // Write, then read back on the next cycle
    set_wr(0, 5, 2'b10); cyc(); clr();
    set_rd(0, 5); expect_rd(0, 2'b10); cyc(); clr();
    // A read and a write to the same word in one cycle return the old value
    set_wr(0, 5, 2'b01); set_rd(0, 5); expect_rd(0, 2'b10); cyc(); clr();
    set_rd(0, 5); expect_rd(0, 2'b01); cyc(); clr();
    set_wr(0, 7, 2'b11); cyc(); clr();

    // ch0 releases and ch1 takes the RAM with no gap
    req = 2'b10; cyc();
    chk("handoff_ch1", 32'(gnt), 32'b10);
    set_wr(1, 7, 2'b01); cyc(); clr();
    set_wr(1, 3, 2'b00); cyc(); clr();
    set_rd(1, 7); expect_rd(1, 2'b01); cyc(); clr();

    // ch1 holds while ch0 requests, then releases
    req = 2'b11; cyc();
    chk("ch1_holds", 32'(gnt), 32'b10);
    req = 2'b01; cyc();
    chk("rr_to_ch0", 32'(gnt), 32'b01);

    // Both request and ch0 holds for 3 cycles. ch1 tries a write and a
    // read while it does not own the RAM.
    req = 2'b11;
    set_rd(0, 7); expect_rd(0, 2'b11); set_wr(1, 3, 2'b11);
    cyc();
    chk("ch0_hold1", 32'(gnt), 32'b01);
    ren[0] = 1'b0; set_rd(1, 3);
    cyc();
    chk("ch0_hold2", 32'(gnt), 32'b01);
    cyc();
    chk("ch0_hold3", 32'(gnt), 32'b01);
    clr();
    req = 2'b10; cyc();
    chk("rr_to_ch1", 32'(gnt), 32'b10);
    // Bank 1 addr 3 must still hold 2'b00
    set_rd(1, 3); expect_rd(1, 2'b00); cyc(); clr();

    // From IDLE after ch1 last won, a simultaneous request goes to ch0
    req = 2'b00; cyc();
    chk("idle_gnt2", 32'(gnt), 32'd0);
    chk("idle_state", 32'(state), 32'd0);
    req = 2'b11; cyc();
    chk("idle_rr_ch0", 32'(gnt), 32'b01);
    // Next round from IDLE: ch0 may not win twice in a row
    req = 2'b00; cyc();
    req = 2'b11; cyc();
    chk("no_double_win", 32'(gnt), 32'b10);
    req = 2'b01; cyc();
    chk("back_to_ch0", 32'(gnt), 32'b01);

    // Read issued in ch0's last owning cycle still returns to ch0
    req = 2'b11; set_rd(0, 5); expect_rd(0, 2'b01); cyc(); clr();
    chk("inflight_gnt", 32'(gnt), 32'b01);
    req = 2'b10; cyc();
    chk("inflight_handoff", 32'(gnt), 32'b10);

    // Reset during a burst: the read accepted at this edge is discarded
    set_rd(1, 7);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    clr(); req = '0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Contents written before the reset are still there
    req = 2'b10; cyc();
    chk("post_rst_gnt", 32'(gnt), 32'b10);
    set_rd(1, 7); expect_rd(1, 2'b01); cyc();
    clr(); set_rd(1, 3); expect_rd(1, 2'b00); cyc(); clr();
    req = 2'b01; cyc();
    chk("post_rst_ch0", 32'(gnt), 32'b01);
    set_rd(0, 7); expect_rd(0, 2'b11); cyc();
    clr(); set_rd(0, 5); expect_rd(0, 2'b01); cyc(); clr();

`ifdef SERV_RF_SHARED_PARITY_EN
    // Corrupt the parity bit of bank 1 addr 7; the data bits stay 2'b01
    chk("perr_clean", 32'(perr), 32'd0);
    req = 2'b10; cyc();
    dut.mem[1][7][W] = ~dut.mem[1][7][W];
    set_rd(1, 7); expect_rd(1, 2'b01); cyc(); clr();
    cyc();
    chk("perr_set", 32'(perr), 32'd1);
    chk("perr_ch", 32'(perr_ch), 32'd1);
    set_rd(1, 3); expect_rd(1, 2'b00); cyc(); clr();
    cyc();
    chk("perr_sticky", 32'(perr), 32'd1);
    rst_n = 1'b0; #1;
    chk("perr_rst", 32'({perr, perr_ch}), 32'd0);
    req = '0; cyc();
    rst_n = 1'b1;
`endif

    repeat (3) cyc();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
